cordic_rotator: RTL and testbench

//  Iterative CORDIC engine in rotation mode, the inverse of the vectoring datapath.

---
 rtl/cordic_pkg.sv | 44 ++++
 rtl/cordic_rotator_register.sv | 29 ++
 rtl/cordic_rotator.sv | 188 ++++++++++++++++++
 tb/tb_cordic_rotator.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : cordic_pkg
//  Description : Shared constants for the rotation-mode CORDIC engine:
//                FSM state encoding, arctangent table and 1/K gain constant.
//  Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ROTATE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // 1/K in Q1.15, for users that want to compensate the CORDIC gain
    localparam logic [15:0] CORDIC_K1 = 16'h4DBA;

    // round(atan(2^-i)/pi * 32768): binary-angle units where 0x8000 = pi
    function automatic logic [15:0] cordic_atan(input int unsigned i);
        logic [15:0] v;
        case (i)
            0:       v = 16'h2000;
            1:       v = 16'h12E4;
            2:       v = 16'h09FB;
            3:       v = 16'h0511;
            4:       v = 16'd651;
            5:       v = 16'd326;
            6:       v = 16'd163;
            7:       v = 16'd81;
            8:       v = 16'd41;
            9:       v = 16'd20;
            10:      v = 16'd10;
            11:      v = 16'd5;
            12:      v = 16'd3;
            13:      v = 16'd1;
            14:      v = 16'd1;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_rotator_register.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : register
//  Description : Loadable register with asynchronous active-low reset.
//                Holds its value until ld is asserted.
//  Revision    : 1.0 - initial release
// ============================================================================
module register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d when ld is high, otherwise hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cordic_rotator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : cordic_rotator
//  Description : Iterative rotation-mode CORDIC. Rotates (x_in, y_in) by z_in
//                one micro-rotation per cycle; outputs carry the uncompensated
//                CORDIC gain and the residual angle.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_rotator
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic signed [WIDTH+1:0] x_out,
    output logic signed [WIDTH+1:0] y_out,
    output logic signed [WIDTH-1:0] z_out,
    output logic                    busy,
    output logic                    done
);

    localparam int XW = WIDTH + 2;
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0]    C_LAST    = CW'(ITER - 1);
    localparam logic [WIDTH-1:0] C_QUARTER = {2'b01, {(WIDTH-2){1'b0}}};

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [CW-1:0]           r_cnt;
    logic signed [XW-1:0]    r_x;
    logic signed [XW-1:0]    r_y;
    logic signed [WIDTH-1:0] r_z;

    logic                    w_load;
    logic                    w_last;
    logic signed [XW-1:0]    w_x_ext;
    logic signed [XW-1:0]    w_y_ext;
    logic signed [XW-1:0]    w_x_ld;
    logic signed [XW-1:0]    w_y_ld;
    logic signed [WIDTH-1:0] w_z_ld;
    logic signed [XW-1:0]    w_x_sh;
    logic signed [XW-1:0]    w_y_sh;
    logic                    w_dpos;
    logic [15:0]             w_atan16;
    logic signed [WIDTH-1:0] w_atan;
    logic signed [XW-1:0]    w_x_nxt;
    logic signed [XW-1:0]    w_y_nxt;
    logic signed [WIDTH-1:0] w_z_nxt;

    // A new operation is accepted only while idle or in the completion cycle
    assign w_load = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    // The last micro-rotation also loads the output registers
    assign w_last = (r_state == ST_ROTATE) && (r_cnt == C_LAST);

    assign w_x_ext = {{2{x_in[WIDTH-1]}}, x_in};
    assign w_y_ext = {{2{y_in[WIDTH-1]}}, y_in};

    // Quadrant pre-rotation by +-pi/2 so the iterations only need to cover +-pi/2
    always_comb begin
        w_x_ld = w_x_ext;
        w_y_ld = w_y_ext;
        w_z_ld = z_in;
        case (z_in[WIDTH-1 -: 2])
            2'b01: begin
                w_x_ld = -w_y_ext;
                w_y_ld = w_x_ext;
                w_z_ld = z_in - C_QUARTER;
            end
            2'b10: begin
                w_x_ld = w_y_ext;
                w_y_ld = -w_x_ext;
                w_z_ld = z_in + C_QUARTER;
            end
            default: ;
        endcase
    end

    // The atan table is in 16-bit binary-angle units; rescale to WIDTH
    assign w_atan16 = cordic_atan(32'(r_cnt));

    generate
        if (WIDTH == 16) begin : g_atan_eq
            assign w_atan = w_atan16;
        end else if (WIDTH > 16) begin : g_atan_wide
            assign w_atan = WIDTH'(w_atan16) << (WIDTH - 16);
        end else begin : g_atan_narrow
            assign w_atan = WIDTH'(w_atan16 >> (16 - WIDTH));
        end
    endgenerate

    // One micro-rotation: direction chosen from the sign of the residual angle
    assign w_x_sh  = r_x >>> r_cnt;
    assign w_y_sh  = r_y >>> r_cnt;
    assign w_dpos  = ~r_z[WIDTH-1];
    assign w_x_nxt = w_dpos ? (r_x - w_y_sh)  : (r_x + w_y_sh);
    assign w_y_nxt = w_dpos ? (r_y + w_x_sh)  : (r_y - w_x_sh);
    assign w_z_nxt = w_dpos ? (r_z - w_atan)  : (r_z + w_atan);

    // Working vector, angle and iteration counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_z   <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_x   <= w_x_ld;
            r_y   <= w_y_ld;
            r_z   <= w_z_ld;
            r_cnt <= '0;
        end else if (r_state == ST_ROTATE) begin
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
            r_z   <= w_z_nxt;
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_ROTATE;
                end
            end
            ST_ROTATE: begin
                busy = 1'b1;
                if (r_cnt == C_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = start ? ST_ROTATE : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Result registers: loaded with the final iteration and held until the next completion
    register #(.WIDTH(XW)) u_x_out (
        .clk (clk),
        .rst (rst),
        .ld  (w_last),
        .d   (w_x_nxt),
        .q   (x_out)
    );

    register #(.WIDTH(XW)) u_y_out (
        .clk (clk),
        .rst (rst),
        .ld  (w_last),
        .d   (w_y_nxt),
        .q   (y_out)
    );

    register #(.WIDTH(WIDTH)) u_z_out (
        .clk (clk),
        .rst (rst),
        .ld  (w_last),
        .d   (w_z_nxt),
        .q   (z_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_cordic_rotator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_cordic_rotator
//  Description : Self-checking bench for cordic_rotator. An integer CORDIC
//                model (arctangents from $atan) plus an ideal real-valued
//                rotation provide expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_rotator;

    localparam int  WIDTH = 16;
    localparam int  ITER  = 15;
    localparam int  TOL   = 4;
    localparam int  RTOL  = 64;
    localparam real PI    = 3.14159265358979323846;

    logic                    clk   = 1'b0;
    logic                    rst   = 1'b0;
    logic                    start = 1'b0;
    logic signed [WIDTH-1:0] x_in  = '0;
    logic signed [WIDTH-1:0] y_in  = '0;
    logic signed [WIDTH-1:0] z_in  = '0;
    logic signed [WIDTH+1:0] x_out;
    logic signed [WIDTH+1:0] y_out;
    logic signed [WIDTH-1:0] z_out;
    logic                    busy;
    logic                    done;

    int  checks = 0;
    int  errors = 0;
    int  atan_tab[ITER];
    real gain;

    always #5 clk = ~clk;

    cordic_rotator #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x_in  (x_in),
        .y_in  (y_in),
        .z_in  (z_in),
        .x_out (x_out),
        .y_out (y_out),
        .z_out (z_out),
        .busy  (busy),
        .done  (done)
    );

    function automatic int absd(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Integer CORDIC from the algorithm definition: quadrant fold, then ITER micro-rotations
    function automatic void model(input logic [15:0] xi, input logic [15:0] yi,
                                  input logic [15:0] zi,
                                  output int xo, output int yo, output int zo);
        longint x, y, z, xs, ys;
        x = longint'($signed(xi));
        y = longint'($signed(yi));
        z = longint'($signed(zi));
        if (zi[15:14] == 2'b01) begin
            x = -longint'($signed(yi));
            y = longint'($signed(xi));
            z = z - 16384;
        end else if (zi[15:14] == 2'b10) begin
            x = longint'($signed(yi));
            y = -longint'($signed(xi));
            z = z + 16384;
        end
        for (int i = 0; i < ITER; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            if (z >= 0) begin
                x = x - ys; y = y + xs; z = z - atan_tab[i];
            end else begin
                x = x + ys; y = y - xs; z = z + atan_tab[i];
            end
            z = longint'(shortint'(z));
        end
        xo = int'(x);
        yo = int'(y);
        zo = int'(z);
    endfunction

    // Ideal gain-scaled rotation in real arithmetic
    function automatic void ideal(input logic [15:0] xi, input logic [15:0] yi,
                                  input logic [15:0] zi, output int xo, output int yo);
        real th, xr, yr;
        th = real'($signed(zi)) * PI / 32768.0;
        xr = real'($signed(xi));
        yr = real'($signed(yi));
        xo = int'(gain * (xr * $cos(th) - yr * $sin(th)));
        yo = int'(gain * (xr * $sin(th) + yr * $cos(th)));
    endfunction

    // Pulse start for one cycle and wait (bounded) for done; lat = edges from load to done
    task automatic do_op(input logic [15:0] xi, input logic [15:0] yi, input logic [15:0] zi,
                         output int lat, output logic dbl);
        @(posedge clk); #1;
        x_in = xi; y_in = yi; z_in = zi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!done && lat < 100);
        @(negedge clk);
        dbl = done;
    endtask

    task automatic test_reset();
        x_in = 16'sd1234; y_in = 16'sd777; z_in = 16'sh1000; start = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (x_out !== '0) begin errors++; $display("FAIL reset_x got %0d want 0", x_out); end
        checks++; if (y_out !== '0) begin errors++; $display("FAIL reset_y got %0d want 0", y_out); end
        checks++; if (z_out !== '0) begin errors++; $display("FAIL reset_z got %0d want 0", z_out); end
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_directed();
        logic [15:0] zs[4];
        logic [15:0] xv[2];
        logic [15:0] yv[2];
        int lat, ex, ey, ez, rx, ry;
        logic dbl;
        zs = '{16'h0000, 16'h2000, 16'h6000, 16'h8000};
        xv = '{16'd10000, 16'h8000};
        yv = '{16'd0, 16'h8000};
        for (int v = 0; v < 2; v++) begin
            for (int k = 0; k < 4; k++) begin
                model(xv[v], yv[v], zs[k], ex, ey, ez);
                ideal(xv[v], yv[v], zs[k], rx, ry);
                do_op(xv[v], yv[v], zs[k], lat, dbl);
                checks++; if (lat !== ITER) begin errors++; $display("FAIL dir_latency z=%h got %0d want %0d", zs[k], lat, ITER); end
                checks++; if (dbl !== 1'b0) begin errors++; $display("FAIL dir_done_width z=%h done still %b want 0", zs[k], dbl); end
                checks++; if (absd(int'(x_out), ex) > TOL) begin errors++; $display("FAIL dir_x v=%0d z=%h got %0d want %0d", v, zs[k], x_out, ex); end
                checks++; if (absd(int'(y_out), ey) > TOL) begin errors++; $display("FAIL dir_y v=%0d z=%h got %0d want %0d", v, zs[k], y_out, ey); end
                checks++; if (absd(int'(z_out), ez) > TOL) begin errors++; $display("FAIL dir_z v=%0d z=%h got %0d want %0d", v, zs[k], z_out, ez); end
                checks++; if (absd(int'(x_out), rx) > RTOL) begin errors++; $display("FAIL dir_ideal_x v=%0d z=%h got %0d want %0d", v, zs[k], x_out, rx); end
                checks++; if (absd(int'(y_out), ry) > RTOL) begin errors++; $display("FAIL dir_ideal_y v=%0d z=%h got %0d want %0d", v, zs[k], y_out, ry); end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] xi, yi, zi;
        int lat, ex, ey, ez;
        logic dbl;
        for (int n = 0; n < 40; n++) begin
            xi = 16'($urandom);
            yi = 16'($urandom);
            zi = 16'($urandom);
            model(xi, yi, zi, ex, ey, ez);
            do_op(xi, yi, zi, lat, dbl);
            checks++; if (lat !== ITER) begin errors++; $display("FAIL rnd_latency n=%0d got %0d want %0d", n, lat, ITER); end
            checks++; if (absd(int'(x_out), ex) > TOL) begin errors++; $display("FAIL rnd_x in=%h,%h,%h got %0d want %0d", xi, yi, zi, x_out, ex); end
            checks++; if (absd(int'(y_out), ey) > TOL) begin errors++; $display("FAIL rnd_y in=%h,%h,%h got %0d want %0d", xi, yi, zi, y_out, ey); end
            checks++; if (absd(int'(z_out), ez) > TOL) begin errors++; $display("FAIL rnd_z in=%h,%h,%h got %0d want %0d", xi, yi, zi, z_out, ez); end
        end
    endtask

    // start pulsed and inputs changed mid-operation must have no effect
    task automatic test_ignore_start();
        int ex, ey, ez, ndone;
        model(16'd5000, 16'hF000, 16'h3000, ex, ey, ez);
        @(posedge clk); #1;
        x_in = 16'sd5000; y_in = 16'shF000; z_in = 16'sh3000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= ITER + 8; c++) begin
            @(posedge clk); #1;
            if (c == 3) begin
                x_in = 16'sd100; y_in = 16'sd200; z_in = 16'shC000; start = 1'b1;
            end
            if (c == 4) start = 1'b0;
            @(negedge clk);
            if (done) ndone++;
        end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
        checks++; if (absd(int'(x_out), ex) > TOL) begin errors++; $display("FAIL ignore_x got %0d want %0d", x_out, ex); end
        checks++; if (absd(int'(y_out), ey) > TOL) begin errors++; $display("FAIL ignore_y got %0d want %0d", y_out, ey); end
        checks++; if (absd(int'(z_out), ez) > TOL) begin errors++; $display("FAIL ignore_z got %0d want %0d", z_out, ez); end
    endtask

    // start held high: a completion every ITER+1 cycles
    task automatic test_back_to_back();
        int ex, ey, ez;
        int times[$];
        model(16'hA123, 16'd20000, 16'h9ABC, ex, ey, ez);
        @(posedge clk); #1;
        x_in = 16'shA123; y_in = 16'sd20000; z_in = 16'sh9ABC; start = 1'b1;
        for (int c = 0; c < 3 * (ITER + 1); c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                times.push_back(c);
                checks++; if (absd(int'(x_out), ex) > TOL) begin errors++; $display("FAIL b2b_x c=%0d got %0d want %0d", c, x_out, ex); end
                checks++; if (absd(int'(y_out), ey) > TOL) begin errors++; $display("FAIL b2b_y c=%0d got %0d want %0d", c, y_out, ey); end
            end
        end
        start = 1'b0;
        checks++;
        if (times.size() !== 3) begin
            errors++; $display("FAIL b2b_count got %0d want 3", times.size());
        end else begin
            checks++; if (times[0] !== ITER) begin errors++; $display("FAIL b2b_first got %0d want %0d", times[0], ITER); end
            checks++; if (times[1] - times[0] !== ITER + 1) begin errors++; $display("FAIL b2b_gap1 got %0d want %0d", times[1] - times[0], ITER + 1); end
            checks++; if (times[2] - times[1] !== ITER + 1) begin errors++; $display("FAIL b2b_gap2 got %0d want %0d", times[2] - times[1], ITER + 1); end
        end
        repeat (2) @(negedge clk);
    endtask

    // Reset asserted at iteration 5, then a fresh operation
    task automatic test_reset_mid();
        int lat, ex, ey, ez;
        logic dbl;
        @(posedge clk); #1;
        x_in = 16'sd12000; y_in = 16'sd3000; z_in = 16'sh1800; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
        checks++; if (x_out !== '0) begin errors++; $display("FAIL midrst_x got %0d want 0", x_out); end
        checks++; if (y_out !== '0) begin errors++; $display("FAIL midrst_y got %0d want 0", y_out); end
        checks++; if (z_out !== '0) begin errors++; $display("FAIL midrst_z got %0d want 0", z_out); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < ITER; c++) begin
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_no_done c=%0d got %b want 0", c, done); end
        end
        model(16'hE000, 16'd9000, 16'hD000, ex, ey, ez);
        do_op(16'hE000, 16'd9000, 16'hD000, lat, dbl);
        checks++; if (lat !== ITER) begin errors++; $display("FAIL post_latency got %0d want %0d", lat, ITER); end
        checks++; if (absd(int'(x_out), ex) > TOL) begin errors++; $display("FAIL post_x got %0d want %0d", x_out, ex); end
        checks++; if (absd(int'(y_out), ey) > TOL) begin errors++; $display("FAIL post_y got %0d want %0d", y_out, ey); end
        checks++; if (absd(int'(z_out), ez) > TOL) begin errors++; $display("FAIL post_z got %0d want %0d", z_out, ez); end
    endtask

    initial begin
        gain = 1.0;
        for (int i = 0; i < ITER; i++) begin
            atan_tab[i] = int'($floor($atan($pow(2.0, real'(-i))) / PI * 32768.0 + 0.5));
            gain = gain * $sqrt(1.0 + $pow(2.0, real'(-2 * i)));
        end
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
